// File: rtl/tree_classifier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tree_classifier_arbiter
//  Description : Round-robin front end that shares one decision-tree
//                classifier core among NREQ feature-frame requesters. It
//                latches the winner's five features, issues a single-cycle
//                start, waits for the core's result (with a watchdog) and
//                returns the class to the winner with a one-cycle done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tree_classifier_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*160-1:0]       req_feat,
  output logic [NREQ-1:0]           done,
  output logic [2:0]                class_out,
  output logic                      class_err,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic                      busy,
  output logic                      dt_start,
  output logic [31:0]               dt_in1,
  output logic [31:0]               dt_in2,
  output logic [31:0]               dt_in3,
  output logic [31:0]               dt_in4,
  output logic [31:0]               dt_in5,
  input  logic                      dt_busy,
  input  logic                      dt_valid,
  input  logic [2:0]                dt_class
);

  localparam int c_idx_w  = $clog2(NREQ);
  localparam int c_wdog_w = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [c_idx_w-1:0]   r_ptr;
  logic [c_idx_w-1:0]   r_grant;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic [159:0]         r_feat;
  logic [c_wdog_w-1:0]  r_wdog;
  logic [c_wdog_w-1:0]  w_wdog_inc;
  logic                 w_wdog_expired;
  logic [2:0]           r_class;
  logic                 r_class_err;

  // w_wdog_inc is the number of WAIT cycles spent including the current one;
  // the request is abandoned once that count reaches TIMEOUT, so done lands
  // TIMEOUT+1 cycles after the start pulse.
  assign w_wdog_inc     = r_wdog + 1'b1;
  assign w_wdog_expired = (w_wdog_inc == c_wdog_w'(TIMEOUT));

  // Round-robin pick: first set request scanning upward from ptr+1 with wrap.
  // Iterating from the farthest candidate down leaves the nearest one as the
  // final assignment, which is the winner.
  always_comb begin
    w_pick_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_pick_idx = c_idx_w'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; req is only looked at while idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|req)                       w_state_next = S_ISSUE;
      S_ISSUE: if (!dt_busy)                   w_state_next = S_WAIT;
      S_WAIT:  if (dt_valid || w_wdog_expired) w_state_next = S_RESP;
      S_RESP:                                  w_state_next = S_IDLE;
      default:                                 w_state_next = S_IDLE;
    endcase
  end

  // Datapath: grant/feature latch, watchdog, result capture and pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= c_idx_w'(NREQ - 1);
      r_grant     <= '0;
      r_feat      <= '0;
      r_wdog      <= '0;
      r_class     <= '0;
      r_class_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant <= w_pick_idx;
            r_feat  <= req_feat[int'(w_pick_idx)*160 +: 160];
          end
        end
        S_ISSUE: begin
          if (!dt_busy) begin
            r_wdog <= '0;
          end
        end
        S_WAIT: begin
          r_wdog <= w_wdog_inc;
          // A genuine answer beats a simultaneous watchdog expiry.
          if (dt_valid) begin
            r_class     <= dt_class;
            r_class_err <= 1'b0;
          end else if (w_wdog_expired) begin
            r_class     <= 3'b111;
            r_class_err <= 1'b1;
          end
        end
        S_RESP: begin
          r_ptr <= r_grant;
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

  // One-hot completion strobe towards the served requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_done
    assign done[i] = (r_state == S_RESP) && (r_grant == c_idx_w'(i));
  end

  assign dt_start  = (r_state == S_ISSUE) && !dt_busy;
  assign busy      = (r_state != S_IDLE);
  assign grant_idx = r_grant;
  assign class_out = r_class;
  assign class_err = r_class_err;
  assign dt_in1    = r_feat[31:0];
  assign dt_in2    = r_feat[63:32];
  assign dt_in3    = r_feat[95:64];
  assign dt_in4    = r_feat[127:96];
  assign dt_in5    = r_feat[159:128];

endmodule
`default_nettype wire

// File: tb/tb_tree_classifier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tree_classifier_arbiter
//  Description : Self-checking bench for tree_classifier_arbiter with a
//                behavioural classifier-core stub and a transaction-level
//                round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_classifier_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*160-1:0]  req_feat;
  logic [NREQ-1:0]      done;
  logic [2:0]           class_out;
  logic                 class_err;
  logic [1:0]           grant_idx;
  logic                 busy;
  logic                 dt_start;
  logic [31:0]          dt_in1, dt_in2, dt_in3, dt_in4, dt_in5;
  logic                 dt_busy;
  logic                 dt_valid;
  logic [2:0]           dt_class;

  tree_classifier_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_feat(req_feat),
    .done(done), .class_out(class_out), .class_err(class_err),
    .grant_idx(grant_idx), .busy(busy), .dt_start(dt_start),
    .dt_in1(dt_in1), .dt_in2(dt_in2), .dt_in3(dt_in3), .dt_in4(dt_in4),
    .dt_in5(dt_in5), .dt_busy(dt_busy), .dt_valid(dt_valid), .dt_class(dt_class)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Core stub state, controlled by the main sequence.
  int           stub_lat    = 2;
  logic [2:0]   stub_cls    = 3'd0;
  bit           stub_mute   = 1'b0;
  bit           stub_kill   = 1'b0;
  bit           stub_inject = 1'b0;
  int           stub_cnt    = 0;
  logic [2:0]   pend_cls    = 3'd0;
  int           starts      = 0;
  int           last_start  = -1;
  bit           prev_start  = 1'b0;
  logic [159:0] exp_feat    = '0;

  // Reference model state.
  int              ptr_m;
  logic [NREQ-1:0] mask;
  bit              refill_pend = 1'b0;
  int              refill_bit  = 0;
  int              refill_cyc  = 0;

  // Classifier-core stub: answers stub_lat cycles after each start pulse.
  initial begin : core_stub
    dt_valid = 1'b0;
    dt_class = 3'd0;
    forever begin
      @(negedge clk);
      dt_valid = 1'b0;
      if (stub_kill) begin
        stub_cnt  = 0;
        stub_kill = 1'b0;
      end
      if (stub_cnt != 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          dt_valid = 1'b1;
          dt_class = pend_cls;
        end
      end
      if (stub_inject) begin
        dt_valid    = 1'b1;
        dt_class    = 3'd2;
        stub_inject = 1'b0;
      end
      if (dt_start === 1'b1) begin
        check_eq("start_gap", 160'(prev_start), 160'(0));
        check_eq("start_feat", {dt_in5, dt_in4, dt_in3, dt_in2, dt_in1}, exp_feat);
        starts++;
        last_start = cyc;
        if (!stub_mute) begin
          stub_cnt = stub_lat;
          pend_cls = stub_cls;
        end
      end
      prev_start = (dt_start === 1'b1);
    end
  end

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_slice(input int i);
    for (int w = 0; w < 5; w++) req_feat[i*160 + w*32 +: 32] = $urandom;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (refill_pend && cyc >= refill_cyc) begin
        req[refill_bit]  = 1'b1;
        mask[refill_bit] = 1'b1;
        rand_slice(refill_bit);
        refill_pend = 1'b0;
      end
      if (done !== '0) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) check_eq("done_seen", 160'(|done), 160'(1));
  endtask

  // Serve up to ntx transactions from mask m; with refill, a served requester
  // re-raises its request two cycles after its done.
  task automatic run_chain(input logic [NREQ-1:0] m, input int ntx, input bit refill,
                           input int fix_lat, input int fix_cls);
    int g, d, w, lat, st0;
    logic [2:0] cls;
    mask = m;
    for (int i = 0; i < NREQ; i++) if (m[i]) rand_slice(i);
    req = m;
    g = cyc;
    for (int t = 0; t < ntx; t++) begin
      w   = pick(mask, ptr_m);
      lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 6));
      cls = (fix_cls >= 0) ? 3'(fix_cls) : 3'($urandom_range(0, 7));
      stub_lat = lat;
      stub_cls = cls;
      exp_feat = req_feat[w*160 +: 160];
      st0 = starts;
      wait_done(40, d);
      if (d < 0) return;
      check_eq("done_vec",    160'(done),           160'(1 << w));
      check_eq("done_cycle",  160'(d - g),          160'(lat + 2));
      check_eq("start_cycle", 160'(last_start - g), 160'(1));
      check_eq("start_count", 160'(starts - st0),   160'(1));
      check_eq("class_out",   160'(class_out),      160'(cls));
      check_eq("class_err",   160'(class_err),      160'(0));
      check_eq("grant_idx",   160'(grant_idx),      160'(w));
      ptr_m   = w;
      mask[w] = 1'b0;
      req[w]  = 1'b0;
      if (refill) begin
        refill_pend = 1'b1;
        refill_bit  = w;
        refill_cyc  = d + 2;
      end
      @(negedge clk);
      if (mask != '0) begin
        g = cyc;
      end else if (refill) begin
        @(negedge clk);
        req[refill_bit]  = 1'b1;
        mask[refill_bit] = 1'b1;
        rand_slice(refill_bit);
        refill_pend = 1'b0;
        g = cyc;
      end else begin
        break;
      end
    end
    req  = '0;
    mask = '0;
    refill_pend = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int g, d, w, st0;
    bit activity;
    rst      = 1'b0;
    req      = '0;
    req_feat = '0;
    dt_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done",  160'(done),      160'(0));
    check_eq("rst_busy",  160'(busy),      160'(0));
    check_eq("rst_start", 160'(dt_start),  160'(0));
    check_eq("rst_class", 160'({class_err, class_out}), 160'(0));
    check_eq("rst_grant", 160'(grant_idx), 160'(0));
    check_eq("rst_feat",  {dt_in5, dt_in4, dt_in3, dt_in2, dt_in1}, 160'(0));
    rst   = 1'b1;
    ptr_m = NREQ - 1;
    @(negedge clk);

    // Directed: fixed-latency single requests, then ordering cases.
    run_chain(4'b0001, 1, 1'b0, 2, 0);
    run_chain(4'b0001, 1, 1'b0, 3, 4);
    run_chain(4'b1010, 2, 1'b0, 0, -1);
    run_chain(4'b1111, 5, 1'b1, 0, -1);

    // Core busy for five cycles on entering ISSUE.
    req = 4'b1000;
    rand_slice(3);
    w = pick(req, ptr_m);
    exp_feat = req_feat[w*160 +: 160];
    stub_lat = 3;
    stub_cls = 3'd5;
    dt_busy  = 1'b1;
    g   = cyc;
    st0 = starts;
    repeat (6) @(posedge clk);
    #1 dt_busy = 1'b0;
    wait_done(40, d);
    check_eq("busy_start_cycle", 160'(last_start - g), 160'(6));
    check_eq("busy_start_count", 160'(starts - st0),   160'(1));
    check_eq("busy_done_cycle",  160'(d - g),          160'(10));
    check_eq("busy_done_vec",    160'(done),           160'(1 << w));
    check_eq("busy_class",       160'({class_err, class_out}), 160'({1'b0, 3'd5}));
    ptr_m = w;
    req   = '0;
    repeat (2) @(negedge clk);

    // Core that never answers: watchdog abort, then a late answer is ignored.
    req = 4'b0100;
    rand_slice(2);
    w = pick(req, ptr_m);
    exp_feat  = req_feat[w*160 +: 160];
    stub_mute = 1'b1;
    g = cyc;
    wait_done(TIMEOUT + 20, d);
    check_eq("to_start_cycle", 160'(last_start - g), 160'(1));
    check_eq("to_done_cycle",  160'(d - last_start), 160'(TIMEOUT + 1));
    check_eq("to_done_vec",    160'(done),           160'(1 << w));
    check_eq("to_class",       160'({class_err, class_out}), 160'({1'b1, 3'd7}));
    ptr_m = w;
    req   = '0;
    repeat (3) @(negedge clk);
    stub_inject = 1'b1;
    activity = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== '0) activity = 1'b1;
    end
    check_eq("late_valid_ignored", 160'(activity), 160'(0));
    check_eq("to_class_held", 160'({class_err, class_out}), 160'({1'b1, 3'd7}));
    stub_mute = 1'b0;

    // Asynchronous reset in the middle of WAIT, then re-service.
    req = 4'b0101;
    rand_slice(0);
    rand_slice(2);
    w = pick(req, ptr_m);
    exp_feat = req_feat[w*160 +: 160];
    stub_lat = 30;
    st0 = starts;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (starts != st0) break;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_done",  160'(done),      160'(0));
    check_eq("arst_busy",  160'(busy),      160'(0));
    check_eq("arst_start", 160'(dt_start),  160'(0));
    check_eq("arst_class", 160'({class_err, class_out}), 160'(0));
    check_eq("arst_grant", 160'(grant_idx), 160'(0));
    check_eq("arst_feat",  {dt_in5, dt_in4, dt_in3, dt_in2, dt_in1}, 160'(0));
    stub_kill = 1'b1;
    ptr_m = NREQ - 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_chain(4'b0101, 2, 1'b0, 0, -1);

    // Randomized traffic.
    for (int r = 0; r < 25; r++) begin
      run_chain(4'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
                1'($urandom_range(0, 1)), 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/tree_classifier_arbiter.md
Name: tree_classifier_arbiter

Overview:
- Shares one decision-tree classifier core among NREQ feature-frame requesters.
- Arbitrates round-robin and latches the winner's five 32-bit float features.
- Issues a single-cycle start to the core, waits for its valid pulse, and returns the class to the winner with a one-cycle done strobe.
- Sits between the sensor feature-extraction channels and the classifier core. A watchdog recovers from a core that never answers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 63, maximum WAIT cycles before the request is aborted (≥8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req  in  NREQ  per-requester level request; held until matching done.
- req_feat  in  NREQ*160  features; slice i = {f5,f4,f3,f2,f1} of requester i, f1 in bits [i*160+31:i*160].
- done  out  NREQ  one-hot, one-cycle completion strobe.
- class_out  out  3  class for the completed request; valid while done≠0.
- class_err  out  1  high with done when the request timed out.
- grant_idx  out  $clog2(NREQ)  index currently being served.
- busy  out  1  high in every state except IDLE.
- dt_start  out  1  start pulse to the core.
- dt_in1..dt_in5  out  32 each  latched features to the core.
- dt_busy  in  1  core busy.
- dt_valid  in  1  core result-valid pulse.
- dt_class  in  3  core class result.

Behaviour:
- Reset values: state=IDLE; done=0; class_out=0; class_err=0; grant_idx=0; busy=0; dt_start=0; dt_in1..5=0; rr pointer=NREQ-1; wdog counter=0.
- Reset mid-operation aborts the request with no done strobe. The requester must keep req asserted and is re-served after reset.
- IDLE:
  - If req≠0, select the first set bit scanning from (ptr+1) mod NREQ upward with wrap.
  - Latch the selected slice into dt_in1..5, set grant_idx and busy=1, go to ISSUE.
  - req is sampled only in IDLE; changes in other states are ignored.
- ISSUE:
  - If dt_busy=0, drive dt_start=1 for exactly this cycle, clear wdog, go to WAIT.
  - If dt_busy=1, hold dt_start=0 and stay; the wdog does not count here.
- WAIT:
  - wdog increments each cycle.
  - dt_valid=1 → class_out<=dt_class, class_err<=0, go to RESP.
  - Else if wdog==TIMEOUT → class_out<=3'b111, class_err<=1, go to RESP.
  - dt_valid and timeout in the same cycle: dt_valid wins.
- RESP:
  - done[grant_idx]=1 for one cycle; class_out and class_err held valid.
  - ptr<=grant_idx, busy<=0, go to IDLE.
  - class_out and class_err keep their values until the next RESP.
- Requester contract: req[i] is low by the cycle after done[i]. The IDLE following RESP therefore never re-grants the same request.
- dt_valid outside WAIT (e.g. a late answer after timeout) is ignored.
- dt_in1..5 are stable from ISSUE until the next IDLE grant.
- dt_start is never high outside ISSUE and never on two consecutive cycles.
- Latency: done rises 2 cycles after dt_valid's start cycle… in absolute terms, done = (cycles from dt_start to dt_valid) + 2 after the IDLE grant cycle. For a 2-cycle core answer, done is 4 cycles after req is first seen in IDLE.
- Fairness: with all requesters asserting continuously, the service order is 0,1,…,NREQ-1,0,…

Test Plan:
- Single request, core attached: req[0]=1, f3=0x3f800000 → done[0] exactly 4 cycles after the IDLE grant cycle, class_out=0, class_err=0.
- Same with f3=0x3e800000, f2=0x3f800000 → done[0] 5 cycles after grant, class_out=4.
- req=4'b1010 in the same cycle after reset → requester 1 is served first (done[1]), then requester 3. Continuous req=4'b1111 → done order 0,1,2,3,0.
- Core stub never pulses dt_valid → done pulses exactly TIMEOUT+1 cycles after dt_start with class_out=7 and class_err=1. A dt_valid injected 3 cycles later is ignored.
- dt_busy held high 5 cycles on entering ISSUE → dt_start asserts on the first cycle dt_busy=0, exactly one pulse, and the result is still correct.
- rst driven low asynchronously mid-WAIT → all outputs go to reset values immediately with no done. After release the pending req is re-served with the correct class.
